// File: rtl/reg_scoreboard.sv
// Register-write scoreboard: per-register counters of outstanding writes, used to
// stall the ID stage while a source register still has a pending writeback.
module reg_scoreboard #(
    parameter int CNT_W     = 2,
    parameter bit WB_BYPASS = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [4:0]         rs1_addr,
    input  logic [4:0]         rs2_addr,
    input  logic               rs1_used,
    input  logic               rs2_used,
    input  logic               issue_valid,
    input  logic               issue_we,
    input  logic [4:0]         issue_rd,
    input  logic               wb_we,
    input  logic [4:0]         wb_rd,
    input  logic               kill_valid,
    input  logic [4:0]         kill_rd,
    output logic               stall,
    output logic [31:0]        busy_mask,
    output logic [CNT_W+4:0]   inflight,
    output logic               err
);

    localparam int SUM_W   = CNT_W + 5;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic [CNT_W-1:0] r_cnt [1:31];
    logic [31:0]      r_busy;
    logic [SUM_W-1:0] r_inflight;
    logic             r_err;

    logic [CNT_W-1:0] w_cnt [32];
    logic [CNT_W-1:0] w_cntNext [1:31];
    logic [31:0]      w_busyNext;
    logic [SUM_W-1:0] w_sumNext;
    logic             w_errEvent;
    logic             w_wbHit1;
    logic             w_wbHit2;
    logic             w_hz1;
    logic             w_hz2;
    logic             w_accept;
    int               w_sum;

    // Register 0 is a constant-zero slot so source lookups need no special index range.
    always_comb begin
        w_cnt[0] = '0;
        for (int i = 1; i < 32; i++) begin
            w_cnt[i] = r_cnt[i];
        end
    end

    // Hazard check uses only state and wb inputs, never issue_*, to keep ID acceptance loop-free.
    always_comb begin
        w_wbHit1 = WB_BYPASS && wb_we && (wb_rd == rs1_addr);
        w_wbHit2 = WB_BYPASS && wb_we && (wb_rd == rs2_addr);
        w_hz1    = (rs1_addr != 5'd0) && (w_cnt[rs1_addr] > CNT_W'(w_wbHit1));
        w_hz2    = (rs2_addr != 5'd0) && (w_cnt[rs2_addr] > CNT_W'(w_wbHit2));
        stall    = (rs1_used && w_hz1) || (rs2_used && w_hz2);
        w_accept = issue_valid && !stall;
    end

    // All events on a register are summed first, then clamped once, so err only
    // fires when the net change leaves the counter range.
    always_comb begin
        w_errEvent    = 1'b0;
        w_busyNext    = '0;
        w_sumNext     = '0;
        w_sum         = 0;
        for (int i = 1; i < 32; i++) begin
            w_sum = int'(r_cnt[i])
                  + int'(w_accept && issue_we && (issue_rd == 5'(i)))
                  - int'(wb_we && (wb_rd == 5'(i)))
                  - int'(kill_valid && (kill_rd == 5'(i)));
            if (w_sum > CNT_MAX) begin
                w_cntNext[i] = CNT_W'(CNT_MAX);
                w_errEvent   = 1'b1;
            end else if (w_sum < 0) begin
                w_cntNext[i] = '0;
                w_errEvent   = 1'b1;
            end else begin
                w_cntNext[i] = CNT_W'(w_sum);
            end
            w_busyNext[i] = (w_cntNext[i] != '0);
            w_sumNext     = w_sumNext + {5'd0, w_cntNext[i]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < 32; i++) begin
                r_cnt[i] <= '0;
            end
            r_busy     <= '0;
            r_inflight <= '0;
            r_err      <= 1'b0;
        end else begin
            for (int i = 1; i < 32; i++) begin
                r_cnt[i] <= w_cntNext[i];
            end
            r_busy     <= w_busyNext;
            r_inflight <= w_sumNext;
            r_err      <= r_err | w_errEvent;
        end
    end

    assign busy_mask = r_busy;
    assign inflight  = r_inflight;
    assign err       = r_err;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed self-checking bench for reg_scoreboard (CNT_W=2, WB_BYPASS=1).
module tb_reg_scoreboard;

    logic        clk;
    logic        rst;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        rs1_used;
    logic        rs2_used;
    logic        issue_valid;
    logic        issue_we;
    logic [4:0]  issue_rd;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic        kill_valid;
    logic [4:0]  kill_rd;
    logic        stall;
    logic [31:0] busy_mask;
    logic [6:0]  inflight;
    logic        err;

    int testsRun    = 0;
    int testsFailed = 0;

    reg_scoreboard #(.CNT_W(2), .WB_BYPASS(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rs1_used   (rs1_used),
        .rs2_used   (rs2_used),
        .issue_valid(issue_valid),
        .issue_we   (issue_we),
        .issue_rd   (issue_rd),
        .wb_we      (wb_we),
        .wb_rd      (wb_rd),
        .kill_valid (kill_valid),
        .kill_rd    (kill_rd),
        .stall      (stall),
        .busy_mask  (busy_mask),
        .inflight   (inflight),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic iv, input logic [4:0] ird,
                                 input logic wv, input logic [4:0] wrd,
                                 input logic kv, input logic [4:0] krd);
        issue_valid = iv;
        issue_we    = iv;
        issue_rd    = ird;
        wb_we       = wv;
        wb_rd       = wrd;
        kill_valid  = kv;
        kill_rd     = krd;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        rs1_addr = 5'd0;
        rs2_addr = 5'd0;
        rs1_used = 1'b0;
        rs2_used = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseReset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        #3;
        checkOutput("reset_busy", busy_mask, 32'h0);
        checkOutput("reset_inflight", 32'(inflight), 32'd0);
        checkOutput("reset_err", 32'(err), 32'd0);
        rs1_addr = 5'd5; rs1_used = 1'b1; rs2_addr = 5'd31; rs2_used = 1'b1;
        #1;
        checkOutput("reset_stall", 32'(stall), 32'd0);
        tick();
        rst = 1'b0;
        idle();
        tick();

        // Issue rd5, then read it back: stall until writeback bypass
        applyStimulus(1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        idle();
        rs1_addr = 5'd5; rs1_used = 1'b1;
        applyStimulus(1'b1, 5'd10, 1'b0, 5'd0, 1'b0, 5'd0);
        #1;
        checkOutput("a_stall_rd5", 32'(stall), 32'd1);
        checkOutput("a_busy_rd5", busy_mask, 32'h0000_0020);
        checkOutput("a_inflight_1", 32'(inflight), 32'd1);
        tick();
        checkOutput("a_stalled_issue_dropped", 32'(inflight), 32'd1);
        checkOutput("a_stall_hold", 32'(stall), 32'd1);
        applyStimulus(1'b0, 5'd0, 1'b1, 5'd5, 1'b0, 5'd0);
        #1;
        checkOutput("a_stall_bypass", 32'(stall), 32'd0);
        checkOutput("a_busy_during_wb", busy_mask, 32'h0000_0020);
        tick();
        idle();
        #1;
        checkOutput("a_busy_after_wb", busy_mask, 32'h0);
        checkOutput("a_inflight_after_wb", 32'(inflight), 32'd0);
        checkOutput("a_err_clean", 32'(err), 32'd0);

        // Writes to x0 are never tracked
        applyStimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        idle();
        rs1_addr = 5'd0; rs1_used = 1'b1;
        #1;
        checkOutput("b_busy_x0", busy_mask, 32'h0);
        checkOutput("b_inflight_x0", 32'(inflight), 32'd0);
        checkOutput("b_stall_x0", 32'(stall), 32'd0);

        // Saturate rd7 at 3, then overflow sets err
        idle();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0);
            tick();
        end
        idle();
        #1;
        checkOutput("c_inflight_3", 32'(inflight), 32'd3);
        checkOutput("c_busy_rd7", busy_mask, 32'h0000_0080);
        checkOutput("c_err_before", 32'(err), 32'd0);
        rs2_addr = 5'd7; rs2_used = 1'b1;
        #1;
        checkOutput("c_stall_rs2", 32'(stall), 32'd1);
        idle();
        applyStimulus(1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        idle();
        #1;
        checkOutput("c_err_overflow", 32'(err), 32'd1);
        checkOutput("c_inflight_sat", 32'(inflight), 32'd3);
        applyStimulus(1'b1, 5'd8, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        idle();
        #1;
        checkOutput("c_inflight_4", 32'(inflight), 32'd4);

        // Asynchronous reset between edges
        rst = 1'b1;
        rs1_addr = 5'd7; rs1_used = 1'b1;
        rs2_addr = 5'd8; rs2_used = 1'b1;
        #1;
        checkOutput("r_busy_async", busy_mask, 32'h0);
        checkOutput("r_inflight_async", 32'(inflight), 32'd0);
        checkOutput("r_err_async", 32'(err), 32'd0);
        checkOutput("r_stall_async", 32'(stall), 32'd0);
        rst = 1'b0;
        idle();
        tick();

        // Simultaneous events on rd9
        applyStimulus(1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        applyStimulus(1'b1, 5'd9, 1'b1, 5'd9, 1'b0, 5'd0);
        tick();
        idle();
        #1;
        checkOutput("d_issue_wb_net0", 32'(inflight), 32'd1);
        checkOutput("d_busy_rd9", busy_mask, 32'h0000_0200);
        checkOutput("d_err_net0", 32'(err), 32'd0);
        applyStimulus(1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        checkOutput("d_inflight_2", 32'(inflight), 32'd2);
        applyStimulus(1'b0, 5'd0, 1'b1, 5'd9, 1'b1, 5'd9);
        tick();
        idle();
        #1;
        checkOutput("d_wb_kill_inflight", 32'(inflight), 32'd0);
        checkOutput("d_wb_kill_busy", busy_mask, 32'h0);
        checkOutput("d_wb_kill_err", 32'(err), 32'd0);

        // Underflow on rd12, err sticky through later traffic
        applyStimulus(1'b0, 5'd0, 1'b1, 5'd12, 1'b0, 5'd0);
        tick();
        idle();
        #1;
        checkOutput("e_err_underflow", 32'(err), 32'd1);
        checkOutput("e_inflight_clamp", 32'(inflight), 32'd0);
        checkOutput("e_busy_clamp", busy_mask, 32'h0);
        applyStimulus(1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        checkOutput("e_inflight_rd3", 32'(inflight), 32'd1);
        applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3);
        tick();
        idle();
        #1;
        checkOutput("e_kill_rd3", 32'(inflight), 32'd0);
        checkOutput("e_err_sticky", 32'(err), 32'd1);
        pulseReset();
        checkOutput("e_err_cleared", 32'(err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 Parameter CNT_W, default 2: width of each per-register in-flight counter.
REQ-002 Parameter WB_BYPASS, default 1: when 1, a same-cycle writeback to the last in-flight write of a register removes that register's hazard in that cycle.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 rs1_addr  input  5  source register 1 of the instruction in ID (Inst[19:15]).
REQ-006 rs2_addr  input  5  source register 2 of the instruction in ID (Inst[24:20]).
REQ-007 rs1_used, rs2_used  input  1 each  the ID instruction reads that source.
REQ-008 issue_valid  input  1  an instruction is leaving ID this cycle.
REQ-009 issue_we  input  1  the leaving instruction writes rd (RegWrite from the control unit).
REQ-010 issue_rd  input  5  rd of the leaving instruction (Inst[11:7]).
REQ-011 wb_we  input  1  the WB stage writes the register file this cycle.
REQ-012 wb_rd  input  5  the WB write address.
REQ-013 kill_valid  input  1  an in-flight writing instruction is squashed this cycle.
REQ-014 kill_rd  input  5  rd of the squashed instruction.
REQ-015 stall  output  1  the ID instruction must hold; combinational.
REQ-016 busy_mask  output  32  bit i is 1 when register i has count > 0; registered state.
REQ-017 inflight  output  CNT_W+5  total of all counters; registered.
REQ-018 err  output  1  sticky overflow/underflow flag.

Function
REQ-019 Each of registers 1..31 SHALL have a CNT_W-bit counter of outstanding writes; register 0 SHALL have no counter and SHALL always read as count 0.
REQ-020 Issue acceptance SHALL equal issue_valid & ~stall; an accepted issue with issue_we=1 and issue_rd != 0 SHALL increment count[issue_rd].
REQ-021 wb_we=1 with wb_rd != 0 SHALL decrement count[wb_rd].
REQ-022 kill_valid=1 with kill_rd != 0 SHALL decrement count[kill_rd].
REQ-023 Simultaneous events on one register SHALL be summed into a single net change of +1, 0, -1 or -2, applied in one cycle.
REQ-024 An increment that would exceed 2^CNT_W-1 SHALL saturate the counter and set err.
REQ-025 A decrement below 0 SHALL clamp the counter at 0 and set err.
REQ-026 Once set, err SHALL hold until reset.
REQ-027 hazard(r) SHALL be (count[r] > 0) when WB_BYPASS=0.
REQ-028 hazard(r) SHALL be (count[r] - (wb_we & wb_rd==r) > 0) when WB_BYPASS=1.
REQ-029 stall SHALL equal (rs1_used & hazard(rs1_addr)) | (rs2_used & hazard(rs2_addr)); address 0 SHALL never stall.
REQ-030 stall SHALL NOT depend on issue_* inputs, so that there is no combinational loop through the ID acceptance logic.
REQ-031 busy_mask and inflight SHALL reflect the counter state after the most recent clock edge (latency 1 cycle from the causing event).
REQ-032 inflight SHALL be the exact sum of all 31 counters, with no wrap-around at its width.

Reset
REQ-033 While rst=1, all counters, busy_mask, inflight and err SHALL be 0 immediately, independent of clk.
REQ-034 Reset asserted mid-operation SHALL discard all outstanding state; events in the cycle rst deasserts SHALL NOT be applied.
REQ-035 Out of reset, stall SHALL be 0 for any rs1_addr and rs2_addr.

Verification
REQ-036 Issue rd=5 in cycle 0, then rs1_addr=5 with rs1_used=1 in cycle 1 -> stall=1 and busy_mask[5]=1 until the wb_we/wb_rd=5 cycle; that cycle stall=0 (WB_BYPASS=1), and busy_mask=0 the cycle after.
REQ-037 Issue rd=0 with issue_we=1, then rs1=0 -> busy_mask=0, inflight=0, stall=0.
REQ-038 Three back-to-back issues to rd=7 (stall held 0 by rs*_used=0) -> count 3, inflight=3; a fourth issue -> err=1, count stays 3.
REQ-039 Same cycle: accepted issue rd=9, wb rd=9, count[9]=1 beforehand -> count[9] stays 1 and err=0; same cycle wb rd=9 plus kill rd=9 with count 2 -> count 0.
REQ-040 wb_we with wb_rd=12 while count[12]=0 -> err=1, count[12]=0, err remains 1 through later traffic until rst.
REQ-041 rst pulsed asynchronously between edges with inflight=4 -> busy_mask, inflight and err read 0 before the next clk edge, and stall=0.
